coder_sched: RTL

Periodic sampling scheduler for the quadrature encoder position counter `coder`. It takes a snapshot of the 16-bit count `pco` every programmed interval in microseconds and computes the signed position delta since the last accepted snapshot. Each sample goes to the motor-control loop over a valid/ready handshake. It sits between `coder.pco` and the speed/position loop, and it reports samples that were dropped because the consumer was busy.

---
 rtl/coder_pkg.sv | 23 ++
 rtl/coder_tick.sv | 28 ++
 rtl/coder_sched.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/coder_pkg.sv
// coder_pkg: shared types and constants for the coder position counter and its
// sampling scheduler (coder_sched).
package coder_pkg;

  // Scheduler state encoding
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PRIME = 2'd1,
    ST_RUN   = 2'd2,
    ST_FAULT = 2'd3
  } sched_state_t;

  localparam int         POS_W   = 16;
  localparam int         SEQ_W   = 8;
  localparam logic [7:0] OVR_MAX = 8'hFF;

  // Quadrature decode modes used by coder
  localparam logic [1:0] TYPE_X1  = 2'd0;
  localparam logic [1:0] TYPE_X2  = 2'd1;
  localparam logic [1:0] TYPE_X4  = 2'd2;
  localparam logic [1:0] TYPE_CNT = 2'd3;

endpackage

// File: rtl/coder_tick.sv
// coder_tick: microsecond tick generator. Counts 0..CLK_PER_US-1 and pulses
// tick on the last count. A synchronous clr holds the count at zero and
// suppresses the tick, so the first tick after clr falls CLK_PER_US cycles later.
module coder_tick #(
  parameter int CLK_PER_US = 80
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  output logic tick
);

  localparam int CW = $clog2(CLK_PER_US);
  localparam logic [CW-1:0] LAST = CW'(CLK_PER_US - 1);

  logic [CW-1:0] cnt_reg;

  // Free-running modulo-CLK_PER_US counter, restarted by clr
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)              cnt_reg <= '0;
    else if (clr)            cnt_reg <= '0;
    else if (cnt_reg == LAST) cnt_reg <= '0;
    else                     cnt_reg <= cnt_reg + 1'b1;
  end

  assign tick = !clr && (cnt_reg == LAST);

endmodule

// File: rtl/coder_sched.sv
// coder_sched: periodic sampler of the coder position count. Every per_lat
// microseconds it snapshots pco, computes the delta from the last accepted
// snapshot and offers it on a valid/ready handshake; strobes that find the
// output slot occupied are counted in ovr_cnt.
// Optional feature macro: CODER_SCHED_VEL_LIMIT_EN (velocity-limit fault).
module coder_sched
  import coder_pkg::*;
#(
  parameter int U_DLY      = 1,
  parameter int CLK_PER_US = 80
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [15:0]      period_us,
  input  logic [POS_W-1:0] pco,
  input  logic [15:0]      vel_limit,
  output logic             smp_valid,
  input  logic             smp_ready,
  output logic [POS_W-1:0] smp_pos,
  output logic [POS_W-1:0] smp_delta,
  output logic [SEQ_W-1:0] smp_seq,
  output logic [7:0]       ovr_cnt,
  output logic             busy,
  output logic             vel_fault
);

  // U_DLY only shapes behavioural models; registers here carry no delay.
  if (U_DLY < 0) begin : g_neg_dly_ignored
  end

  sched_state_t     state_reg, state_next;
  logic             busy_reg;
  logic [15:0]      per_lat_reg, per_cnt_reg;
  logic [POS_W-1:0] prev_reg, pos_reg, delta_reg;
  logic [SEQ_W-1:0] seq_reg;
  logic [7:0]       ovr_reg;
  logic             valid_reg;
  logic             tick, strobe, take, load, drop, fault_hit;
  logic [POS_W-1:0] delta_next;

  coder_tick #(.CLK_PER_US(CLK_PER_US)) u_tick (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (state_reg != ST_RUN),
    .tick  (tick)
  );

  assign strobe     = tick && (per_cnt_reg == per_lat_reg - 16'd1);
  assign take       = en && (state_reg == ST_RUN) && strobe;
  assign load       = take && (!valid_reg || smp_ready);
  assign drop       = take && valid_reg && !smp_ready;
  assign delta_next = pco - prev_reg;

`ifdef CODER_SCHED_VEL_LIMIT_EN
  logic [15:0] lim_lat_reg;
  logic        vel_fault_reg;
  logic [16:0] delta_sx, delta_abs;
  assign delta_sx  = {delta_next[15], delta_next};
  assign delta_abs = delta_next[15] ? (~delta_sx + 17'd1) : delta_sx;
  assign fault_hit = load && (delta_abs > {1'b0, lim_lat_reg});

  // Velocity-limit threshold latched at PRIME; sticky fault cleared by en=0
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lim_lat_reg   <= '0;
      vel_fault_reg <= 1'b0;
    end else begin
      if (en && state_reg == ST_PRIME) lim_lat_reg <= vel_limit;
      if (!en)            vel_fault_reg <= 1'b0;
      else if (fault_hit) vel_fault_reg <= 1'b1;
    end
  end
  assign vel_fault = vel_fault_reg;
`else
  logic unused_vel_limit;
  assign unused_vel_limit = ^vel_limit;
  assign fault_hit        = 1'b0;
  assign vel_fault        = 1'b0;
`endif

  // Next-state logic; en=0 forces IDLE from any state
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE:  if (en) state_next = ST_PRIME;
      ST_PRIME: state_next = ST_RUN;
      ST_RUN:   if (fault_hit) state_next = ST_FAULT;
      ST_FAULT: state_next = ST_FAULT;
      default:  state_next = ST_IDLE;
    endcase
    if (!en) state_next = ST_IDLE;
  end

  // State register and busy flag registered from the next state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= ST_IDLE;
      busy_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      busy_reg  <= (state_next != ST_IDLE);
    end
  end

  // Period latch and period counter (ticks 0..per_lat-1, wraps on strobe)
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      per_lat_reg <= 16'd1;
      per_cnt_reg <= '0;
    end else if (en && state_reg == ST_PRIME) begin
      per_lat_reg <= (period_us == 16'd0) ? 16'd1 : period_us;
      per_cnt_reg <= '0;
    end else if (state_reg == ST_RUN && tick) begin
      per_cnt_reg <= strobe ? 16'd0 : per_cnt_reg + 16'd1;
    end
  end

  // Sample slot: reference position, output data, valid handshake, overruns
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_reg  <= '0;
      pos_reg   <= '0;
      delta_reg <= '0;
      seq_reg   <= '0;
      ovr_reg   <= '0;
      valid_reg <= 1'b0;
    end else begin
      if (en && state_reg == ST_PRIME) begin
        prev_reg <= pco;
        seq_reg  <= '0;
        ovr_reg  <= '0;
      end else if (load) begin
        prev_reg  <= pco;
        pos_reg   <= pco;
        delta_reg <= delta_next;
        seq_reg   <= seq_reg + 1'b1;
      end else if (drop && ovr_reg != OVR_MAX) begin
        ovr_reg <= ovr_reg + 8'd1;
      end

      if (!en)                         valid_reg <= 1'b0;
      else if (load)                   valid_reg <= 1'b1;
      else if (valid_reg && smp_ready) valid_reg <= 1'b0;
    end
  end

  assign smp_valid = valid_reg;
  assign smp_pos   = pos_reg;
  assign smp_delta = delta_reg;
  assign smp_seq   = seq_reg;
  assign ovr_cnt   = ovr_reg;
  assign busy      = busy_reg;

endmodule
